word_uart_tx: RTL and testbench
===============================

# word_uart_tx

Downstream stage of the header inserter. Accepts the 16-bit word stream (three 0xFFFF header words followed by payload), buffers it in a small FIFO and serialises each word as two UART 8N1 bytes, MSB byte first, on a single `tx` line toward the host link. Overruns are never silent: dropped words raise a sticky flag.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); minimum 2.
- `FIFO_DEPTH`, 16: word FIFO depth; power of two, at least 2.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  word strobe; `in_data` is sampled when high (driven by the header stage's shift strobe).
- `in_data`  input  16  word to transmit.
- `tx`  output  1  UART line; idle high.
- `busy`  output  1  high while the FIFO is non-empty or a frame is in progress.
- `full`  output  1  FIFO holds `FIFO_DEPTH` words.
- `overflow`  output  1  sticky; set when a word is dropped.

## Operation
- Reset values: `tx`=1, `busy`=0, `full`=0, `overflow`=0. FIFO empty, FSM in IDLE, byte select = high byte.
- Write: on `in_valid`, if not `full`, push `in_data`. If `full`, drop the word and set `overflow`. The word is dropped even if a pop occurs in the same cycle.
- Pop: in IDLE with FIFO non-empty, pop one word into the shift holding register and go to START with byte select = high.
- FSM states:
  - IDLE
  - START: `tx`=0 for 1 bit.
  - DATA: 8 bits, LSB first.
  - PARITY: only when compiled in.
  - STOP: `tx`=1 for 1 bit.
- After STOP:
  - If the high byte was sent, load the low byte and go to START. There is no idle bit between the two bytes.
  - If the low byte was sent, go to IDLE.
  - IDLE pops again on its next cycle when data is waiting, so back-to-back words are separated by exactly one clock of idle.
- Bit counter: 3 bits. Baud counter: clog2(`CLKS_PER_BIT`) bits. Counters reload to 0 on every state change.
- `overflow` clears only on `rst`.
- Reset mid-frame: `tx` returns to 1 on the next edge and the partial frame is abandoned. FIFO and flags clear.
- FIFO pointers use an extra wrap bit. Full/empty come from pointer compare. Pointer wrap at `FIFO_DEPTH` is exercised by tests.

## Timing
- `in_valid` at edge k, with FIFO empty and FSM idle:
  - word visible in FIFO after edge k;
  - popped at edge k+1;
  - `tx` low from edge k+2.
- Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Frame: 10 bits, or 11 with parity. One word is 20 (22) bit times.
- `busy` rises the cycle after the first write. It falls on the edge that returns to IDLE with the FIFO empty.
- `full` and `overflow` are registered and update on the edge following the causing write.
- Sustained input rate must not exceed one word per 20·`CLKS_PER_BIT`+1 cycles. A 4-word header+payload burst is absorbed by the FIFO.

## Configuration
- `WORD_UART_TX_PARITY_EN`:
  - Defined: a PARITY state is inserted between DATA and STOP, sending even parity (XOR of the 8 data bits). The frame is 11 bits.
  - Undefined: the PARITY state and its logic are absent. The frame is 8N1.

## Structure
- Package `word_uart_tx_pkg` holds:
  - FSM state enum;
  - `DATA_BITS`=8;
  - `FRAME_BITS`, conditional on the macro;
  - default `CLKS_PER_BIT`.
- Sub-module `word_fifo` is a synchronous single-clock FIFO parameterised by width and depth, with push/pop/full/empty.
- The top level contains the FSM, baud counter, shift register and flags.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=16.
- Single word 0x12A5 → bytes 0x12 then 0xA5 decoded. Frame spans 80 cycles. `busy` high throughout, low after.
- Burst FFFF, FFFF, FFFF, 0001 on consecutive cycles → 8 bytes FF×6, 00, 01. No idle between bytes; 1 idle cycle between words. `overflow`=0.
- 18 writes on consecutive cycles into an empty block → word 0 popped, words 1–16 stored, word 17 dropped. `overflow`=1. 17 words are received in order, confirming pointer wrap.
- Assert `rst` during the DATA bits of byte 0x5A → `tx`=1 next cycle. FIFO empty, `busy`=0. The next word 0x00FF transmits cleanly.
- With `WORD_UART_TX_PARITY_EN`, send 0x0301 → parity bit 0 for 0x03, 1 for 0x01. The frame spans 88 cycles.
- Bit-width check: every `tx` transition is spaced at a multiple of 4 cycles from the start-bit edge.

Source files
------------

// File: rtl/word_uart_tx_pkg.sv
// word_uart_tx shared types and constants.
// WORD_UART_TX_PARITY_EN adds an even-parity bit to every byte frame.
package word_uart_tx_pkg;

   localparam int DATA_BITS = 8;

`ifdef WORD_UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   localparam int DEF_CLKS_PER_BIT = 868;
   localparam int DEF_FIFO_DEPTH   = 16;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef WORD_UART_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } tx_state_t;

   // Byte of a word currently on the wire; high byte goes first.
   function automatic logic [7:0] pick_byte(
      input logic [15:0] word,
      input logic        hi
   );
      return hi ? word[15:8] : word[7:0];
   endfunction

endpackage

// File: rtl/word_fifo.sv
// Single-clock word FIFO, synchronous reset.
// Pointers carry a wrap bit so full/empty come from a plain compare.
module word_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign pop_data = mem[rd_ptr[AW-1:0]];

   // Pointer update; the wrap bit toggles every DEPTH entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset since empty masks them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/word_uart_tx.sv
// Word-to-UART serialiser: FIFO, byte FSM, baud timing, flags.
// WORD_UART_TX_PARITY_EN inserts an even-parity bit before STOP.
module word_uart_tx
   import word_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   output logic        tx,
   output logic        busy,
   output logic        full,
   output logic        overflow
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

   tx_state_t   state;
   tx_state_t   state_nxt;
   logic [BW-1:0] baud_cnt;
   logic [BW-1:0] baud_nxt;
   logic [2:0]  bit_cnt;
   logic [2:0]  bit_nxt;
   logic        byte_hi;
   logic        byte_hi_nxt;
   logic [15:0] hold_word;
   logic [7:0]  cur_byte;
   logic        baud_end;
   logic        pop;
   logic        tx_bit;
   logic        tx_q;
   logic        ovf_q;

   logic [15:0] fifo_data;
   logic        fifo_full;
   logic        fifo_empty;

   word_fifo #(
      .WIDTH (16),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid),
      .push_data (in_data),
      .pop       (pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign cur_byte = pick_byte(hold_word, byte_hi);
   assign baud_end = (baud_cnt == BAUD_LAST);

   assign tx       = tx_q;
   assign busy     = !fifo_empty || (state != S_IDLE);
   assign full     = fifo_full;
   assign overflow = ovf_q;

   // Next-state, line level and counter steps for the byte FSM.
   always_comb begin
      state_nxt   = state;
      pop         = 1'b0;
      byte_hi_nxt = byte_hi;
      tx_bit      = 1'b1;
      bit_nxt     = bit_cnt;
      baud_nxt    = baud_end ? '0 : baud_cnt + 1'b1;

      unique case (state)
         S_IDLE: begin
            baud_nxt = '0;
            if (!fifo_empty) begin
               pop         = 1'b1;
               byte_hi_nxt = 1'b1;
               state_nxt   = S_START;
            end
         end
         S_START: begin
            tx_bit = 1'b0;
            if (baud_end) state_nxt = S_DATA;
         end
         S_DATA: begin
            tx_bit = cur_byte[bit_cnt];
            if (baud_end) begin
               if (bit_cnt == BIT_LAST) begin
`ifdef WORD_UART_TX_PARITY_EN
                  state_nxt = S_PARITY;
`else
                  state_nxt = S_STOP;
`endif
               end else begin
                  bit_nxt = bit_cnt + 1'b1;
               end
            end
         end
`ifdef WORD_UART_TX_PARITY_EN
         S_PARITY: begin
            tx_bit = ^cur_byte;
            if (baud_end) state_nxt = S_STOP;
         end
`endif
         S_STOP: begin
            tx_bit = 1'b1;
            if (baud_end) begin
               if (byte_hi) begin
                  byte_hi_nxt = 1'b0;
                  state_nxt   = S_START;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      if (state_nxt != state) begin
         baud_nxt = '0;
         bit_nxt  = '0;
      end
   end

   // FSM state, counters, holding word, registered line and flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         byte_hi   <= 1'b1;
         hold_word <= '0;
         tx_q      <= 1'b1;
         ovf_q     <= 1'b0;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_cnt  <= bit_nxt;
         byte_hi  <= byte_hi_nxt;
         tx_q     <= tx_bit;
         if (pop) hold_word <= fifo_data;
         if (in_valid && fifo_full) ovf_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_word_uart_tx.sv
// Self-checking bench for word_uart_tx with a UART line decoder.
// Honours WORD_UART_TX_PARITY_EN for the parity scenario.
module tb_word_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 16;
`ifdef WORD_UART_TX_PARITY_EN
   localparam int FB  = 11;
   localparam bit PAR = 1'b1;
`else
   localparam int FB  = 10;
   localparam bit PAR = 1'b0;
`endif
   localparam int BYTE_CYC = FB * CPB;
   localparam int WORD_CYC = 2 * BYTE_CYC + 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        tx;
   logic        busy;
   logic        full;
   logic        overflow;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   word_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .tx       (tx),
      .busy     (busy),
      .full     (full),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Line decoder: samples bit centres counted from the start edge.
   logic [7:0] rxq [$];
   int         rx_start [$];
   logic       rx_par [$];
   logic       mon_on = 1'b0;
   int         mon_t = 0;
   int         mon_start = 0;
   logic [7:0] mon_byte = '0;
   logic       mon_par = 1'b0;
   logic       prev_tx = 1'b1;
   int         edge_bad = 0;
   int         frame_bad = 0;

   always @(negedge clk) begin
      prev_tx <= tx;
      if (rst) begin
         mon_on <= 1'b0;
      end else if (!mon_on) begin
         if (tx === 1'b0) begin
            mon_on    <= 1'b1;
            mon_t     <= 1;
            mon_start <= cyc;
         end
      end else begin
         mon_t <= mon_t + 1;
         if (tx !== prev_tx && ((cyc - mon_start) % CPB) != 0)
            edge_bad <= edge_bad + 1;
         if ((mon_t % CPB) == CPB / 2) begin
            if (mon_t / CPB == 0) begin
               if (tx !== 1'b0) frame_bad <= frame_bad + 1;
            end else if (mon_t / CPB <= 8) begin
               mon_byte[(mon_t / CPB) - 1] <= tx;
            end else if (PAR && mon_t / CPB == 9) begin
               mon_par <= tx;
            end else begin
               if (tx !== 1'b1) frame_bad <= frame_bad + 1;
               rxq.push_back(mon_byte);
               rx_start.push_back(mon_start);
               rx_par.push_back(mon_par);
               mon_on <= 1'b0;
            end
         end
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model: byte b of a back-to-back run starts this many cycles in.
   function automatic int byte_offset(input int b);
      return (b / 2) * WORD_CYC + (b % 2) * BYTE_CYC;
   endfunction

   task automatic clear_rx();
      rxq.delete();
      rx_start.delete();
      rx_par.delete();
   endtask

   task automatic push_word(input logic [15:0] w, output int k);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w;
      @(negedge clk);
      in_valid = 1'b0;
      k = cyc;
   endtask

   task automatic wait_bytes(input int n, input int budget,
                             input string tag);
      int t;
      t = 0;
      while (rxq.size() < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk(tag, 32'(rxq.size() >= n), 32'd1);
   endtask

   task automatic settle();
      int t;
      t = 0;
      while (busy !== 1'b0 && t < 4000) begin
         @(negedge clk);
         t++;
      end
      repeat (BYTE_CYC) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_rx();
   endtask

   initial begin
      int k;
      int n;
      int t;
      logic [15:0] words [$];
      logic [7:0]  exp_b [$];

      // Reset values.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Single word 0x12A5.
      clear_rx();
      push_word(16'h12A5, k);
      n = 0;
      t = 0;
      while (busy === 1'b1 && t < 400) begin
         n++;
         @(negedge clk);
         t++;
      end
      chk("single_busy_len", 32'(n), 32'(WORD_CYC));
      wait_bytes(2, 200, "single_rx");
      if (rxq.size() >= 2) begin
         chk("single_b0", 32'(rxq[0]), 32'h12);
         chk("single_b1", 32'(rxq[1]), 32'hA5);
         chk("single_lat", 32'(rx_start[0] - k), 32'd2);
         chk("single_gap", 32'(rx_start[1] - rx_start[0]),
             32'(BYTE_CYC));
      end
      settle();

      // Header burst FFFF x3 + 0001 on consecutive cycles.
      clear_rx();
      words = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 1) k = cyc;
         in_valid = 1'b1;
         in_data  = words[i];
      end
      @(negedge clk);
      in_valid = 1'b0;
      wait_bytes(8, 8 * WORD_CYC, "burst_rx");
      if (rxq.size() >= 8) begin
         for (int b = 0; b < 8; b++) begin
            chk($sformatf("burst_b%0d", b), 32'(rxq[b]),
                32'(b % 2 ? words[b / 2][7:0] : words[b / 2][15:8]));
            chk($sformatf("burst_t%0d", b),
                32'(rx_start[b] - k), 32'(2 + byte_offset(b)));
         end
      end
      chk("burst_ovf", 32'(overflow), 32'd0);
      settle();

      // 18 writes: one word in flight plus DEPTH stored, rest dropped.
      clear_rx();
      words.delete();
      for (int i = 0; i < DEPTH + 2; i++)
         words.push_back(16'($urandom));
      for (int i = 0; i < DEPTH + 2; i++) begin
         @(negedge clk);
         if (i == DEPTH) chk("ovr_notfull", 32'(full), 32'd0);
         if (i == DEPTH + 1) begin
            chk("ovr_full", 32'(full), 32'd1);
            chk("ovr_ovf_pre", 32'(overflow), 32'd0);
         end
         in_valid = 1'b1;
         in_data  = words[i];
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("ovr_ovf_set", 32'(overflow), 32'd1);
      wait_bytes(2 * (DEPTH + 1), 2 * (DEPTH + 2) * WORD_CYC, "ovr_rx");
      if (rxq.size() >= 2 * (DEPTH + 1)) begin
         for (int w = 0; w < DEPTH + 1; w++)
            chk($sformatf("ovr_w%0d", w),
                32'({rxq[2 * w], rxq[2 * w + 1]}), 32'(words[w]));
      end
      settle();
      chk("ovr_count", 32'(rxq.size()), 32'(2 * (DEPTH + 1)));
      chk("ovr_sticky", 32'(overflow), 32'd1);
      do_reset();
      chk("ovr_cleared", 32'(overflow), 32'd0);

      // Random words with legal spacing.
      clear_rx();
      exp_b.delete();
      for (int i = 0; i < 6; i++) begin
         logic [15:0] w;
         w = 16'($urandom);
         exp_b.push_back(w[15:8]);
         exp_b.push_back(w[7:0]);
         push_word(w, k);
         repeat (WORD_CYC + $urandom_range(0, 30)) @(negedge clk);
      end
      wait_bytes(12, 4 * WORD_CYC, "rand_rx");
      for (int b = 0; b < 12 && b < rxq.size(); b++)
         chk($sformatf("rand_b%0d", b), 32'(rxq[b]), 32'(exp_b[b]));
      chk("rand_ovf", 32'(overflow), 32'd0);
      settle();

      // Reset while data bit 0 (a zero) of 0x5A is on the line.
      clear_rx();
      push_word(16'h5A5A, k);
      repeat (7) @(negedge clk);
      chk("mid_tx_low", 32'(tx), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_tx_high", 32'(tx), 32'd1);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_full", 32'(full), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_rx();
      push_word(16'h00FF, k);
      wait_bytes(2, 3 * WORD_CYC, "mid_rx");
      settle();
      chk("mid_count", 32'(rxq.size()), 32'd2);
      if (rxq.size() >= 2) begin
         chk("mid_b0", 32'(rxq[0]), 32'h00);
         chk("mid_b1", 32'(rxq[1]), 32'hFF);
      end

`ifdef WORD_UART_TX_PARITY_EN
      // Even parity on 0x03 and 0x01.
      clear_rx();
      push_word(16'h0301, k);
      wait_bytes(2, 3 * WORD_CYC, "par_rx");
      if (rxq.size() >= 2) begin
         chk("par_b0", 32'(rxq[0]), 32'h03);
         chk("par_b1", 32'(rxq[1]), 32'h01);
         chk("par_p0", 32'(rx_par[0]), 32'd0);
         chk("par_p1", 32'(rx_par[1]), 32'd1);
         chk("par_span", 32'(rx_start[1] + BYTE_CYC - rx_start[0]),
             32'd88);
      end
      settle();
`endif

      chk("bit_edges", 32'(edge_bad), 32'd0);
      chk("framing", 32'(frame_bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
